// File: rtl/decoder_n_scan_pkg.sv
// Shared types and the pure decode function for the decoder_n_scan slice.
// Latency: none (types and combinational helper only).
// Backpressure: n/a.
// Contents: mode_e (output coding), state_e (controller states), dec_f(code, mode, w).
package decoder_pkg;

  // Widest output the decode helper supports (N_IN up to 8).
  localparam int unsigned MAX_W = 256;

  typedef enum logic [1:0] {
    MODE_ONEHOT   = 2'b00,
    MODE_THERM    = 2'b01,
    MODE_ONEHOT_N = 2'b10,
    MODE_BLANK    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  // Decode a binary index into a w-bit pattern; bits at or above w are always 0.
  function automatic logic [MAX_W-1:0] dec_f(input logic [7:0] code, input mode_e mode,
                                             input int unsigned w);
    logic [MAX_W-1:0] r;
    logic [31:0]      c;
    r = '0;
    c = {24'd0, code};
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        case (mode)
          MODE_ONEHOT:   r[i] = (i == c);
          MODE_THERM:    r[i] = (i <= c);
          MODE_ONEHOT_N: r[i] = (i != c);
          default:       r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_n_scan_if.sv
// Handshake/bus bundle between a controller (master) and decoder_n_scan (slave).
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready upstream and out_valid/out_ready downstream.
// Signals: in_valid/in_ready/in_code/in_mode, scan_en/dwell, out_valid/out_ready/Y, scan_idx, busy.
interface decoder_n_scan_if #(
  parameter int N_IN    = 3,
  parameter int DWELL_W = 8
);
  localparam int W = 2 ** N_IN;

  logic               in_valid;
  logic               in_ready;
  logic [N_IN-1:0]    in_code;
  logic [1:0]         in_mode;
  logic               scan_en;
  logic [DWELL_W-1:0] dwell;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       Y;
  logic [N_IN-1:0]    scan_idx;
  logic               busy;

  modport master (
    output in_valid, in_code, in_mode, scan_en, dwell, out_ready,
    input  in_ready, out_valid, Y, scan_idx, busy
  );

  modport slave (
    input  in_valid, in_code, in_mode, scan_en, dwell, out_ready,
    output in_ready, out_valid, Y, scan_idx, busy
  );
endinterface

// File: rtl/decoder_n_scan_dwell_counter.sv
// Loadable down-counter that flags when the current dwell has expired.
// Latency: load takes effect on the next edge; tc_o is combinational from the count.
// Backpressure: none; en_i gates counting and the terminal-count flag.
// Ports: clk, rst, load_i, load_val_i, en_i -> tc_o.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A count of zero means this is the last cycle of the dwell.
  assign tc_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/decoder_n_scan.sv
// Registered binary-to-2^N decoder with valid/ready handshake and autonomous scan mode.
// Latency: 1 cycle from accept to Y; scan indices held dwell+1 cycles each.
// Backpressure: Y held until out_ready in direct mode; in_ready = out_ready & ~scan_en in HOLD.
// Ports: clk, rst (async, active-high), bus (decoder_n_scan_if.slave).
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int DWELL_W = 8
) (
  input logic             clk,
  input logic             rst,
  decoder_n_scan_if.slave bus
);
  localparam int W = 2 ** N_IN;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [W-1:0]    y_q, y_d;
  logic            vld_q, vld_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] idx_nxt;
  logic            in_rdy;
  logic            accept;
  logic            step;
  logic            cnt_load;
  logic            cnt_en;

  function automatic logic [W-1:0] dec_w(input logic [N_IN-1:0] c, input mode_e m);
    return W'(dec_f(8'(c), m, W));
  endfunction

  assign idx_nxt = idx_q + N_IN'(1);  // wraps W-1 -> 0 naturally
  assign accept  = bus.in_valid & in_rdy;

  // The counter reloads on scan entry and at every step that continues the scan,
  // so dwell is sampled once per index.
  assign cnt_en   = (state_q == SCAN);
  assign cnt_load = ((state_q == IDLE) && bus.scan_en) ||
                    ((state_q == SCAN) && step && bus.scan_en);

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (bus.dwell),
    .en_i       (cnt_en),
    .tc_o       (step)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ONEHOT;
      y_q     <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.scan_en)  state_d = SCAN;  // scan wins over a pending input
        else if (accept)  state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready && !accept) state_d = IDLE;
      end
      SCAN: begin
        if (step && !bus.scan_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake and next register contents.
  always_comb begin
    in_rdy = 1'b0;
    mode_d = mode_q;
    y_d    = y_q;
    vld_d  = vld_q;
    idx_d  = idx_q;
    case (state_q)
      IDLE: begin
        in_rdy = ~bus.scan_en;
        if (bus.scan_en) begin
          mode_d = mode_e'(bus.in_mode);
          idx_d  = '0;
          y_d    = dec_w('0, mode_e'(bus.in_mode));
          vld_d  = 1'b1;
        end else if (bus.in_valid) begin
          y_d    = dec_w(bus.in_code, mode_e'(bus.in_mode));
          vld_d  = 1'b1;
        end
      end
      HOLD: begin
        in_rdy = bus.out_ready & ~bus.scan_en;
        if (bus.out_ready) begin
          if (accept) begin
            y_d   = dec_w(bus.in_code, mode_e'(bus.in_mode));
            vld_d = 1'b1;
          end else begin
            y_d   = '0;
            vld_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (step) begin
          if (bus.scan_en) begin
            idx_d = idx_nxt;
            y_d   = dec_w(idx_nxt, mode_q);
          end else begin
            idx_d = '0;
            y_d   = '0;
            vld_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.Y         = y_q;
  assign bus.scan_idx  = idx_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
